// File: rtl/exception_tracker_if.sv
// exception_tracker_if: pipeline entry, control and sticky-record signals.
// master drives valid_in/exc_in/pc_in/stall/flush/exc_ack; slave drives the rest.
interface exception_tracker_if #(
  parameter int CODE_W = 2,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 8
);
  logic              valid_in;
  logic [CODE_W-1:0] exc_in;
  logic [PC_W-1:0]   pc_in;
  logic              stall;
  logic              flush;
  logic              exc_ack;
  logic              valid_out;
  logic [CODE_W-1:0] exc_out;
  logic [PC_W-1:0]   pc_out;
  logic              exc_pending;
  logic [CODE_W-1:0] exc_code_latched;
  logic [PC_W-1:0]   exc_pc_latched;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output valid_in, exc_in, pc_in,
    output stall, flush, exc_ack,
    input  valid_out, exc_out, pc_out,
    input  exc_pending, exc_code_latched,
    input  exc_pc_latched, exc_count
  );

  modport slave (
    input  valid_in, exc_in, pc_in,
    input  stall, flush, exc_ack,
    output valid_out, exc_out, pc_out,
    output exc_pending, exc_code_latched,
    output exc_pc_latched, exc_count
  );
endinterface

// File: rtl/exception_tracker.sv
// exception_tracker: DEPTH-stage exception/PC pipeline with sticky
// first-exception record and saturating retired-exception counter.
// Ports: clk, reset (sync, active-high), bus (exception_tracker_if.slave).
// Option: EXC_AUTO_FLUSH_EN - an exception retire also flushes all stages.
module exception_tracker #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 2,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic reset,
  exception_tracker_if.slave bus
);
  localparam int L = DEPTH - 1;

  logic [DEPTH-1:0]  v_q, v_d;
  logic [CODE_W-1:0] code_q [DEPTH];
  logic [CODE_W-1:0] code_d [DEPTH];
  logic [PC_W-1:0]   pc_q [DEPTH];
  logic [PC_W-1:0]   pc_d [DEPTH];
  logic              pend_q, pend_d;
  logic [CODE_W-1:0] lcode_q, lcode_d;
  logic [PC_W-1:0]   lpc_q, lpc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire;
  logic              exc_ret;
  logic              kill;

  always_comb begin
    retire  = v_q[L] & ~bus.stall;
    exc_ret = retire & (code_q[L] != '0);
`ifdef EXC_AUTO_FLUSH_EN
    kill    = bus.flush | exc_ret;
`else
    kill    = bus.flush;
`endif
    v_d    = v_q;
    code_d = code_q;
    pc_d   = pc_q;
    // Flush wins over stall; the last-stage retire above is
    // evaluated on pre-edge state so a flush never hides it.
    if (kill) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++)
        code_d[i] = '0;
    end else if (!bus.stall) begin
      v_d[0]    = bus.valid_in;
      code_d[0] = bus.exc_in & {CODE_W{bus.valid_in}};
      pc_d[0]   = bus.pc_in;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]    = v_q[i-1];
        code_d[i] = code_q[i-1];
        pc_d[i]   = pc_q[i-1];
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    lcode_d = lcode_q;
    lpc_d   = lpc_q;
    // An ack in the same cycle as a new exception frees the
    // record, so the new one is captured instead of dropped.
    if (exc_ret && (!pend_q || bus.exc_ack)) begin
      pend_d  = 1'b1;
      lcode_d = code_q[L];
      lpc_d   = pc_q[L];
    end else if (bus.exc_ack && !exc_ret) begin
      pend_d  = 1'b0;
    end
    cnt_d = cnt_q;
    if (exc_ret && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        code_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      pend_q  <= 1'b0;
      lcode_q <= '0;
      lpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v_q     <= v_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      lcode_q <= lcode_d;
      lpc_q   <= lpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_out        = v_q[L];
  assign bus.exc_out          = code_q[L] & {CODE_W{v_q[L]}};
  assign bus.pc_out           = pc_q[L];
  assign bus.exc_pending      = pend_q;
  assign bus.exc_code_latched = lcode_q;
  assign bus.exc_pc_latched   = lpc_q;
  assign bus.exc_count        = cnt_q;
endmodule
